// File: rtl/cp0_defs.sv
// Coprocessor-0 shared definitions.
// Register numbers, exception codes, bit positions and write masks.
package cp0_defs;

  localparam logic [31:0] RESET_STATUS_DEF = 32'h0040_0000;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer.
// Count advances every second cycle; IP[7] latches on a match.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic phase;

  // tick phase and Count; a Count load restarts the two-cycle cadence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 1'b0;
      count <= '0;
    end else if (count_we) begin
      phase <= 1'b0;
      count <= wdata;
    end else begin
      phase <= ~phase;
      if (phase) count <= count + 32'd1;
    end
  end

  // Compare register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) compare <= '0;
    else if (compare_we) compare <= wdata;
  end

  // sticky timer interrupt; a Compare write acknowledges it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_int <= 1'b0;
    else if (compare_we) timer_int <= 1'b0;
    else if (count == compare) timer_int <= 1'b1;
  end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file and exception state.
// Exception entry outranks eret, which outranks mtc0.
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] RESET_STATUS = RESET_STATUS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [4:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        int_pending,
  output logic        timer_int
);

  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] cause;
  logic        bd;
  logic [4:0]  exccode;
  logic [4:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;

  assign wr_count   = we && (waddr == REG_COUNT);
  assign wr_compare = we && (waddr == REG_COMPARE);
  assign wr_status  = we && (waddr == REG_STATUS) && !exc_valid && !eret;
  assign wr_cause   = we && (waddr == REG_CAUSE) && !exc_valid;
  assign wr_epc     = we && (waddr == REG_EPC) && !exc_valid;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  // Status: EXL set on entry, cleared by eret, else masked mtc0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) status <= RESET_STATUS;
    else if (exc_valid) status[ST_EXL] <= 1'b1;
    else if (eret) status[ST_EXL] <= 1'b0;
    else if (wr_status)
      status <= (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
  end

  // Cause fields: hw lines sampled, exception info, software IP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bd      <= 1'b0;
      exccode <= '0;
      ip_hw   <= '0;
      ip_sw   <= '0;
    end else begin
      ip_hw <= hw_int;
      if (exc_valid) begin
        exccode <= exc_code;
        if (!status[ST_EXL]) bd <= exc_bd;
      end else if (wr_cause) begin
        ip_sw <= wdata[9:8];
      end
    end
  end

  // EPC: first-level exception captures the restart PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) epc <= '0;
    else if (exc_valid && !status[ST_EXL])
      epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
    else if (wr_epc) epc <= wdata;
  end

  // BadVAddr: captured on address errors only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) badvaddr <= '0;
    else if (exc_valid && is_addr_exc(exc_code))
      badvaddr <= exc_badvaddr;
  end

  assign cause = {bd, 15'b0, timer_int, ip_hw, ip_sw,
                  1'b0, exccode, 2'b0};

  assign status_o = status;
  assign cause_o  = cause;
  assign epc_o    = epc;

  assign int_pending = status[ST_IE] & ~status[ST_EXL]
                     & |(cause[15:8] & status[15:8]);

  // read port, no write bypass
  always_comb begin
    rdata = '0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = status;
      REG_CAUSE:    rdata = cause;
      REG_EPC:      rdata = epc;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile.
// Scoreboard against a behavioural CP0 model.
module tb_cp0_regfile;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [4:0]  hw;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] bva;
    logic        eret;
  } stim_t;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        intp;
    logic        ti;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  stim_t       cur;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [4:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        int_pending;
  logic        timer_int;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_status, m_epc, m_badv, m_load, m_cmp;
  int unsigned m_c;
  logic        m_bd, m_ip7;
  logic [4:0]  m_exc, m_hw;
  logic [1:0]  m_sw;

  assign we           = cur.we;
  assign waddr        = cur.waddr;
  assign wdata        = cur.wdata;
  assign raddr        = cur.raddr;
  assign hw_int       = cur.hw;
  assign exc_valid    = cur.exc;
  assign exc_code     = cur.code;
  assign exc_pc       = cur.pc;
  assign exc_bd       = cur.bd;
  assign exc_badvaddr = cur.bva;
  assign eret         = cur.eret;

  cp0_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr        (raddr),
    .rdata        (rdata),
    .hw_int       (hw_int),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .status_o     (status_o),
    .cause_o      (cause_o),
    .epc_o        (epc_o),
    .int_pending  (int_pending),
    .timer_int    (timer_int)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_count();
    return m_load + 32'(m_c >> 1);
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, 15'b0, m_ip7, m_hw, m_sw, 1'b0, m_exc, 2'b0};
  endfunction

  function automatic logic m_intp();
    logic [31:0] c;
    c = m_cause();
    return m_status[0] & ~m_status[1] & |(c[15:8] & m_status[15:8]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return m_cmp;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic stim_t idle(input logic [4:0] r);
    stim_t s;
    s = '{default: '0};
    s.raddr = r;
    return s;
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000;
    m_epc = 0; m_badv = 0; m_load = 0; m_cmp = 0; m_c = 0;
    m_bd = 0; m_ip7 = 0; m_exc = 0; m_hw = 0; m_sw = 0;
  endtask

  // one rising edge with the inputs in cur
  task automatic model_edge();
    logic match, exl_old;
    match = (m_count() == m_cmp);
    if (cur.we && cur.waddr == 5'd11) m_ip7 = 1'b0;
    else if (match) m_ip7 = 1'b1;
    if (cur.we && cur.waddr == 5'd9) begin
      m_load = cur.wdata;
      m_c = 0;
    end else begin
      m_c = m_c + 1;
    end
    if (cur.we && cur.waddr == 5'd11) m_cmp = cur.wdata;
    m_hw = cur.hw;
    if (cur.exc) begin
      exl_old = m_status[1];
      m_status[1] = 1'b1;
      m_exc = cur.code;
      if (!exl_old) begin
        m_epc = cur.bd ? cur.pc - 4 : cur.pc;
        m_bd = cur.bd;
      end
      if (cur.code == 5'h04 || cur.code == 5'h05) m_badv = cur.bva;
    end else begin
      if (cur.eret) m_status[1] = 1'b0;
      if (cur.we) begin
        if (cur.waddr == 5'd12 && !cur.eret)
          m_status = {m_status[31:16], cur.wdata[15:8],
                      m_status[7:2], cur.wdata[1:0]};
        if (cur.waddr == 5'd13) m_sw = cur.wdata[9:8];
        if (cur.waddr == 5'd14) m_epc = cur.wdata;
      end
    end
  endtask

  task automatic push();
    exp_t e;
    e.rdata  = m_read(cur.raddr);
    e.status = m_status;
    e.cause  = m_cause();
    e.epc    = m_epc;
    e.intp   = m_intp();
    e.ti     = m_ip7;
    q.push_back(e);
  endtask

  task automatic cmp(input string n, input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
    end
  endtask

  task automatic go(input stim_t s);
    @(posedge clk);
    model_edge();
    #1;
    cur = s;
    push();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [4:0] r);
    stim_t s;
    s = idle(r);
    s.we = 1'b1;
    s.waddr = a;
    s.wdata = d;
    go(s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b1;
    cur = idle(5'd12);
    model_reset();
    push();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push();
  endtask

  // monitor: compare DUT outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("rdata", rdata, e.rdata);
        cmp("status", status_o, e.status);
        cmp("cause", cause_o, e.cause);
        cmp("epc", epc_o, e.epc);
        cmp("int_pending", 32'(int_pending), 32'(e.intp));
        cmp("timer_int", 32'(timer_int), 32'(e.ti));
      end
    end
  end

  initial begin
    stim_t s;
    logic [4:0] regs [8];
    logic [4:0] codes [7];
    regs = '{5'd0, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd31};
    codes = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c};

    rst = 1'b1;
    cur = idle(5'd12);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push();
    #3;
    cmp("reset_status", status_o, 32'h0040_0000);
    cmp("reset_cause", cause_o, 32'h0);
    cmp("reset_epc", epc_o, 32'h0);
    cmp("reset_intp", 32'(int_pending), 32'h0);

    for (int i = 0; i < 10; i++) go(idle(5'd9));
    #3;
    cmp("count_cadence", rdata, 32'd5);

    wr(5'd9, 32'hFFFF_FFFF, 5'd9);
    repeat (3) go(idle(5'd9));
    #3;
    cmp("count_wrap", rdata, 32'd0);

    wr(5'd9, 32'd0, 5'd13);
    wr(5'd11, 32'd4, 5'd13);
    wr(5'd12, 32'h0000_8001, 5'd13);
    for (int i = 0; i < 12; i++) go(idle(5'd13));
    #3;
    cmp("timer_fire", 32'(timer_int), 32'h1);
    cmp("timer_intp", 32'(int_pending), 32'h1);

    wr(5'd11, 32'd100, 5'd13);
    go(idle(5'd13));
    #3;
    cmp("timer_ack", 32'(timer_int), 32'h0);

    s = idle(5'd14);
    s.exc = 1'b1; s.code = 5'h04; s.pc = 32'hBFC0_0104;
    s.bd = 1'b1; s.bva = 32'h0000_1235;
    go(s);
    go(idle(5'd8));
    #3;
    cmp("exc_badvaddr", rdata, 32'h0000_1235);
    cmp("exc_epc", epc_o, 32'hBFC0_0100);
    cmp("exc_cause", cause_o, 32'h8000_0010);
    cmp("exc_status", status_o, 32'h0040_8003);

    s = idle(5'd14);
    s.exc = 1'b1; s.code = 5'h0c; s.pc = 32'h8000_0200;
    go(s);
    go(idle(5'd14));
    #3;
    cmp("nested_epc", rdata, 32'hBFC0_0100);
    cmp("nested_cause", cause_o, 32'h8000_0030);

    s = idle(5'd12);
    s.exc = 1'b1; s.code = 5'h08; s.pc = 32'h8000_0300;
    s.eret = 1'b1; s.we = 1'b1; s.waddr = 5'd12; s.wdata = 32'h0;
    go(s);
    go(idle(5'd12));
    #3;
    cmp("prio_status", status_o, 32'h0040_8003);
    s = idle(5'd12);
    s.eret = 1'b1;
    go(s);
    go(idle(5'd12));
    #3;
    cmp("eret_status", status_o, 32'h0040_8001);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
      end else begin
        s = idle(($urandom_range(0, 3) == 0) ? 5'($urandom)
                 : regs[$urandom_range(0, 7)]);
        s.hw = 5'($urandom);
        if ($urandom_range(0, 15) == 0) begin
          s.exc = 1'b1;
          s.code = codes[$urandom_range(0, 6)];
          s.pc = $urandom;
          s.bd = 1'($urandom);
          s.bva = $urandom;
        end
        if ($urandom_range(0, 11) == 0) s.eret = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          s.we = 1'b1;
          s.waddr = ($urandom_range(0, 4) == 0) ? 5'($urandom)
                    : regs[$urandom_range(1, 7)];
          s.wdata = ($urandom_range(0, 1) == 0) ? $urandom
                    : m_count() + 32'($urandom_range(0, 6));
        end
        go(s);
      end
    end

    @(negedge clk);
    #1;
    cmp("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
